// File: rtl/wavetable_reader.sv
// Wavetable oscillator: per sample tick, fetch two adjacent table words from a
// 1-cycle-latency memory, linearly interpolate them, and offer the result on valid/ready.
module wavetable_reader #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 24
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                enable,
  input  logic                sample_tick,
  input  logic [PHASE_W-1:0]  phase_inc,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_clken,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [1:0]          mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [DATA_W-1:0]   sample_out,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                busy,
  output logic                overrun
);

  localparam int FRAC_W = 8;
  localparam int DIFF_W = DATA_W + 1;
  localparam int PROD_W = DIFF_W + FRAC_W + 1;

  typedef enum logic [2:0] {IDLE, RD0, RD1, CAP, INTERP, OUT} state_t;

  state_t                     state_q, state_d;
  logic [PHASE_W-1:0]         phase_acc_q, phase_acc_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic                       cs_q, cs_d;
  logic                       valid_q, valid_d;
  logic                       overrun_q, overrun_d;
  logic [FRAC_W-1:0]          frac_q, frac_d;
  logic signed [DATA_W-1:0]   s0_q, s0_d, s1_q, s1_d;
  logic signed [DATA_W-1:0]   sample_q, sample_d;
  logic                       tick_en;

  // s0 + floor((s1 - s0) * f / 256); the result lies between s0 and s1, so no saturation.
  function automatic logic signed [DATA_W-1:0] lerp(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b,
                                                    input logic [FRAC_W-1:0]        f);
    logic signed [DIFF_W-1:0] diff;
    logic signed [PROD_W-1:0] diff_x, f_x, prod, sum;
    diff   = {b[DATA_W-1], b} - {a[DATA_W-1], a};
    diff_x = {{(PROD_W-DIFF_W){diff[DIFF_W-1]}}, diff};
    f_x    = $signed({{(PROD_W-FRAC_W){1'b0}}, f});
    prod   = diff_x * f_x;
    sum    = (prod >>> FRAC_W) + {{(PROD_W-DATA_W){a[DATA_W-1]}}, a};
    return sum[DATA_W-1:0];
  endfunction

  assign tick_en = enable && sample_tick;

  always_comb begin
    state_d     = state_q;
    phase_acc_d = phase_acc_q;
    addr_d      = addr_q;
    cs_d        = cs_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frac_d      = frac_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    sample_d    = sample_q;
    case (state_q)
      IDLE: begin
        if (tick_en) begin
          phase_acc_d = phase_acc_q + phase_inc;
          addr_d      = phase_acc_q[PHASE_W-1 -: ADDR_W];
          frac_d      = phase_acc_q[PHASE_W-ADDR_W-1 -: FRAC_W];
          cs_d        = 1'b1;
          state_d     = RD0;
        end
      end
      RD0: begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = RD1;
      end
      RD1: begin
        s0_d    = mem_readdata;
        cs_d    = 1'b0;
        state_d = CAP;
      end
      CAP: begin
        s1_d    = mem_readdata;
        state_d = INTERP;
      end
      INTERP: begin
        sample_d = lerp(s0_q, s1_q, frac_q);
        valid_d  = 1'b1;
        state_d  = OUT;
      end
      OUT: begin
        if (valid_q && sample_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Any enabled tick outside IDLE is dropped and flagged.
    if (tick_en && state_q != IDLE) overrun_d = 1'b1;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= IDLE;
      phase_acc_q <= '0;
      addr_q      <= '0;
      cs_q        <= 1'b0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_acc_q <= phase_acc_d;
      addr_q      <= addr_d;
      cs_q        <= cs_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk_clk) begin
    frac_q <= frac_d;
    s0_q   <= s0_d;
    s1_q   <= s1_d;
  end

  assign mem_address    = addr_q;
  assign mem_chipselect = cs_q;
  assign mem_clken      = cs_q;
  assign mem_write      = 1'b0;
  assign mem_writedata  = '0;
  assign mem_byteenable = 2'b11;
  assign sample_out     = sample_q;
  assign sample_valid   = valid_q;
  assign busy           = (state_q != IDLE);
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_wavetable_reader.sv
// Self-checking bench for wavetable_reader: behavioural phase/interpolation model,
// a 1-cycle-latency table memory, and per-scenario tasks.
module tb_wavetable_reader;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b0;
  logic        enable = 1'b0;
  logic        sample_tick = 1'b0;
  logic [23:0] phase_inc = '0;
  logic [7:0]  mem_address;
  logic        mem_chipselect, mem_clken, mem_write;
  logic [15:0] mem_writedata;
  logic [1:0]  mem_byteenable;
  logic [15:0] mem_readdata = '0;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        sample_ready = 1'b1;
  logic        busy, overrun;

  int passed = 0;
  int total  = 0;
  int unsigned model_phase = 0;
  logic [15:0] mem [256];

  wavetable_reader dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .enable(enable),
    .sample_tick(sample_tick), .phase_inc(phase_inc),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata), .sample_out(sample_out), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .busy(busy), .overrun(overrun)
  );

  always #5 clk_clk = ~clk_clk;

  always @(posedge clk_clk)
    if (mem_chipselect && mem_clken) mem_readdata <= mem[mem_address];

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  // Linear interpolation between table[i] and table[i+1] with floor rounding.
  function automatic logic [15:0] ref_sample(input int unsigned ph);
    int idx, f, s0, s1, p, q;
    idx = int'((ph >> 16) & 255);
    f   = int'((ph >> 8) & 255);
    s0  = $signed(mem[idx]);
    s1  = $signed(mem[(idx + 1) % 256]);
    p   = (s1 - s0) * f;
    q   = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    return 16'(s0 + q);
  endfunction

  task automatic do_reset();
    reset_reset = 1'b1; sample_tick = 1'b0;
    step(); step();
    reset_reset = 1'b0;
    model_phase = 0;
  endtask

  task automatic do_fetch(input logic [23:0] inc, input int hold, output logic [15:0] got);
    logic [7:0]  a;
    logic [15:0] exp, held;
    a   = 8'((model_phase >> 16) & 255);
    exp = ref_sample(model_phase);
    model_phase = (model_phase + inc) & 32'hFFFFFF;
    sample_ready = 1'b1;
    enable = 1'b1; phase_inc = inc; sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    enable = 1'($urandom % 2);
    phase_inc = 24'($urandom);
    total++; if (mem_address !== a) $display("FAIL fetch_addr0 got %h exp %h", mem_address, a); else passed++;
    total++; if ({mem_chipselect, mem_clken, busy} !== 3'b111) $display("FAIL fetch_cs got %b exp 111", {mem_chipselect, mem_clken, busy}); else passed++;
    step();
    total++; if (mem_address !== 8'(a + 8'd1)) $display("FAIL fetch_addr1 got %h exp %h", mem_address, 8'(a + 8'd1)); else passed++;
    step();
    total++; if (mem_chipselect !== 1'b0) $display("FAIL fetch_cs_drop got %b exp 0", mem_chipselect); else passed++;
    step();
    total++; if (sample_valid !== 1'b0) $display("FAIL fetch_early_valid got %b exp 0", sample_valid); else passed++;
    step();
    total++; if (sample_valid !== 1'b1) $display("FAIL fetch_valid got %b exp 1", sample_valid); else passed++;
    total++; if (sample_out !== exp) $display("FAIL fetch_sample got %h exp %h", sample_out, exp); else passed++;
    got  = sample_out;
    held = sample_out;
    if (hold > 0) begin
      sample_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        step();
        total++; if ({sample_valid, sample_out} !== {1'b1, held}) $display("FAIL hold_stable got %b/%h exp 1/%h", sample_valid, sample_out, held); else passed++;
      end
      sample_ready = 1'b1;
    end
    step();
    total++; if ({sample_valid, busy} !== 2'b00) $display("FAIL fetch_done got %b exp 00", {sample_valid, busy}); else passed++;
  endtask

  task automatic test_reset();
    logic [15:0] got;
    for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);
    do_reset();
    total++; if ({mem_address, mem_chipselect, mem_clken, sample_out, sample_valid, overrun, busy} !== '0)
      $display("FAIL reset_outputs got %h/%b/%b/%h/%b/%b/%b exp all 0", mem_address, mem_chipselect, mem_clken, sample_out, sample_valid, overrun, busy);
    else passed++;
    do_fetch(24'h123456, 0, got);
    enable = 1'b1; phase_inc = 24'h050000; sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    reset_reset = 1'b1;
    step();
    total++; if ({mem_write, mem_writedata, mem_byteenable} !== {1'b0, 16'h0, 2'b11}) $display("FAIL reset_consts got %b/%h/%b exp 0/0000/11", mem_write, mem_writedata, mem_byteenable); else passed++;
    step();
    reset_reset = 1'b0;
    model_phase = 0;
    total++; if ({mem_address, mem_chipselect, mem_clken, sample_out, sample_valid, overrun, busy} !== '0)
      $display("FAIL reset_midfetch got %h/%b/%b/%h/%b/%b/%b exp all 0", mem_address, mem_chipselect, mem_clken, sample_out, sample_valid, overrun, busy);
    else passed++;
    do_fetch(24'($urandom), 0, got);
  endtask

  task automatic test_integer_step();
    logic [15:0] got;
    logic [15:0] want [3] = '{16'h0000, 16'h0010, 16'h0020};
    for (int k = 0; k < 256; k++) mem[k] = 16'(k * 16);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_fetch(24'h010000, 0, got);
      total++; if (got !== want[i]) $display("FAIL int_step%0d got %h exp %h", i, got, want[i]); else passed++;
      step(); step();
    end
  endtask

  task automatic test_interp();
    logic [15:0] got;
    logic [15:0] want [3] = '{16'h0000, 16'h0080, 16'h0100};
    mem[0] = 16'h0000; mem[1] = 16'h0100; mem[2] = 16'h0100;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_fetch(24'h008000, 0, got);
      total++; if (got !== want[i]) $display("FAIL interp%0d got %h exp %h", i, got, want[i]); else passed++;
    end
  endtask

  task automatic test_wrap();
    logic [15:0] got;
    for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);
    mem[255] = 16'h7FFF; mem[0] = 16'h8001;
    do_reset();
    for (int i = 0; i < 255; i++) do_fetch(24'h010000, 0, got);
    do_fetch(24'h008000, 0, got);
    do_fetch(24'($urandom), 0, got);
    total++; if (got !== 16'h0000) $display("FAIL wrap_sample got %h exp 0000", got); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] got;
    for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);
    do_reset();
    for (int i = 0; i < 24; i++) do_fetch(24'($urandom), int'($urandom_range(0, 3)), got);
  endtask

  task automatic test_enable_low();
    logic [15:0] got;
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample_tick = 1'b1; phase_inc = 24'($urandom);
      step();
      total++; if ({mem_chipselect, sample_valid, overrun, busy} !== 4'b0000) $display("FAIL enable_low got %b exp 0000", {mem_chipselect, sample_valid, overrun, busy}); else passed++;
    end
    sample_tick = 1'b0;
    do_fetch(24'($urandom), 0, got);
  endtask

  task automatic test_overrun();
    logic [15:0] got, exp;
    do_reset();
    exp = ref_sample(model_phase);
    model_phase = (model_phase + 32'h0A1234) & 32'hFFFFFF;
    enable = 1'b1; phase_inc = 24'h0A1234; sample_tick = 1'b1;
    step();
    sample_tick = 1'b0; sample_ready = 1'b0;
    repeat (4) step();
    total++; if ({sample_valid, sample_out} !== {1'b1, exp}) $display("FAIL ovr_first got %b/%h exp 1/%h", sample_valid, sample_out, exp); else passed++;
    repeat (3) step();
    sample_tick = 1'b1; phase_inc = 24'h7F0000;
    step();
    sample_tick = 1'b0;
    total++; if ({overrun, sample_valid, busy, sample_out} !== {3'b111, exp}) $display("FAIL ovr_flag got %b%b%b/%h exp 111/%h", overrun, sample_valid, busy, sample_out, exp); else passed++;
    sample_ready = 1'b1;
    step();
    total++; if ({sample_valid, busy} !== 2'b00) $display("FAIL ovr_release got %b exp 00", {sample_valid, busy}); else passed++;
    do_fetch(24'($urandom), 0, got);
    total++; if (overrun !== 1'b1) $display("FAIL ovr_sticky got %b exp 1", overrun); else passed++;
  endtask

  initial begin
    test_reset();
    test_integer_step();
    test_interp();
    test_wrap();
    test_back_to_back();
    test_enable_low();
    test_overrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wavetable_reader.md
Name: wavetable_reader

Overview:
Oscillator stage that reads 16-bit signed wavetable samples through a 256x16 on-chip memory s1 slave port. One fetch runs per audio sample strobe. A 24-bit phase accumulator selects two adjacent table entries, which are linearly interpolated. The result is handed downstream to the codec serializer over a valid/ready handshake. One instance drives each on-chip memory in the synth system.

Parameters:
ADDR_W, 8, memory word address width (table length 2^ADDR_W)
DATA_W, 16, sample and memory data width (signed two's complement)
PHASE_W, 24, phase accumulator width; bits [PHASE_W-1 -: ADDR_W] form the index, the next 8 bits below form the fraction

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  synchronous reset, active-high
enable  in  1  oscillator enable; ticks are ignored while low
sample_tick  in  1  one-cycle audio sample strobe
phase_inc  in  PHASE_W  unsigned phase increment per tick
mem_address  out  ADDR_W  to s1_address
mem_chipselect  out  1  to s1_chipselect
mem_clken  out  1  to s1_clken
mem_write  out  1  to s1_write, constant 0
mem_writedata  out  DATA_W  to s1_writedata, constant 0
mem_byteenable  out  2  to s1_byteenable, constant 2'b11
mem_readdata  in  DATA_W  from s1_readdata; read latency is 1 clock
sample_out  out  DATA_W  interpolated sample
sample_valid  out  1  sample_out valid
sample_ready  in  1  downstream accepts sample
busy  out  1  high whenever state != IDLE
overrun  out  1  sticky flag: a tick arrived while busy

Behaviour:
- Reset (synchronous, highest priority, including mid-fetch): state IDLE; phase_acc, mem_address, mem_chipselect, mem_clken, sample_out, sample_valid and overrun all 0. The next tick after reset uses phase 0.
- mem_address, mem_chipselect, mem_clken and sample_out are registered. mem_clken equals mem_chipselect.
- States: IDLE, RD0, RD1, CAP, INTERP, OUT.
- IDLE, on enable && sample_tick at an edge:
  - latch phase_cur = phase_acc;
  - phase_acc <= phase_acc + phase_inc, modulo 2^PHASE_W (wrap, no saturation);
  - A = phase_cur index bits; drive mem_address=A, chipselect=1;
  - go to RD0.
- RD0: mem_address <= A+1 modulo 2^ADDR_W (255 wraps to 0); go to RD1.
- RD1: s0 <= mem_readdata (= mem[A]); chipselect <= 0; go to CAP.
- CAP: s1 <= mem_readdata (= mem[A+1]); go to INTERP.
- INTERP: sample_out <= s0 + ((s1 - s0) * f) >>> 8.
  - s1 - s0 is a 17-bit signed difference; f = 8-bit unsigned fraction; the product is 25-bit signed.
  - The shift is arithmetic, truncating toward minus infinity.
  - The result always lies between s0 and s1, so it fits DATA_W without saturation.
  - Set sample_valid <= 1; go to OUT.
- OUT: hold sample_out and sample_valid stable while sample_ready is low. At an edge with sample_valid && sample_ready, sample_valid <= 0 and state <= IDLE.
- Latency: sample_valid rises 4 clock edges after the edge that sampled the tick. With sample_ready tied high, valid is high for exactly 1 cycle. Minimum accepted tick spacing is 6 cycles.
- A tick is accepted only in IDLE.
  - Tick with enable high in any other state, including the handshake edge in OUT: tick is dropped, phase_acc is not advanced, overrun <= 1 (sticky until reset).
  - Tick with enable low: ignored, no overrun.
- enable falling mid-fetch: the fetch completes and the sample is delivered normally.
- phase_inc is sampled only at the accept edge; changes at any other time have no effect on the fetch in progress.
- mem_write=0, mem_writedata=0 and mem_byteenable=2'b11 at all times, including during reset.

Test Plan:
- Reset check: assert reset_reset 2 cycles mid-fetch -> next cycle state IDLE, all outputs 0, busy=0; the following tick reads address 0.
- Integer stepping: mem[k]=k*16, phase_inc=0x010000, ticks every 8 cycles, ready=1 -> samples 0x0000, 0x0010, 0x0020. Each sample_valid pulse is 1 cycle wide, 4 edges after its tick. Addresses 0,1 / 1,2 / 2,3 appear on consecutive cycles.
- Interpolation: mem[0]=0x0000, mem[1]=0x0100, mem[2]=0x0100, phase_inc=0x008000 -> samples 0x0000, 0x0080, 0x0100.
- Table wrap with signed extremes: preload phase_acc to 0xFF8000 via 0xFF ticks of 0x010000 then one of 0x008000; mem[255]=0x7FFF, mem[0]=0x8001 -> addresses 255 then 0; sample 0x0000.
- Backpressure and overrun: ready=0, second tick arrives 3 cycles after valid -> overrun=1, sample_out unchanged, phase_acc advanced only once. Raise ready -> one transfer, then IDLE.
- enable low: ticks with enable=0 -> no chipselect, no valid, overrun stays 0, phase_acc unchanged.
